vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Owns the single-port pixel framebuffer RAM behind the VGA display path. Shares it between
//  the scan-out (driven by Display_Controller hCount/vCount/bright) and one host port (game
//  logic) with a req/ack handshake. Produces registered 12-bit rgb for the vgaR/G/B pins.
//  Scan-out always has priority; the host uses every cycle without a display slot.
// PARAMETERS
//  FB_W        80     framebuffer width in cells
//  FB_H        60     framebuffer height in cells
//  SCALE_SHIFT 3      screen pixels per cell = 1<<SCALE_SHIFT (8x8 px per cell)
//  AW          13     RAM address width; must satisfy 2**AW >= FB_W*FB_H
//  BORDER_RGB  12'hFFF  border colour, used only when VGA_FB_BORDER_EN is defined
// PORTS
//  clk         in   1   system clock (board_clk domain)
//  reset_n     in   1   asynchronous reset, active low
//  pix_tick    in   1   one-cycle pulse per pixel from timing gen; at least 2 clk apart
//  hCount      in   10  horizontal pixel count, valid on pix_tick
//  vCount      in   10  vertical line count, valid on pix_tick
//  bright      in   1   active-video flag, valid on pix_tick
//  host_req    in   1   host request; held high until host_ack
//  host_we     in   1   1 = write, 0 = read; stable while host_req
//  host_addr   in   AW  cell address; stable while host_req
//  host_wdata  in   12  write colour; stable while host_req
//  host_ack    out  1   one-cycle completion pulse
//  host_rdata  out  12  read data, valid when host_ack=1
//  mem_en      out  1   RAM enable (combinational)
//  mem_we      out  1   RAM write enable (combinational)
//  mem_addr    out  AW  RAM address (combinational)
//  mem_wdata   out  12  RAM write data (combinational)
//  mem_rdata   in   12  RAM read data, valid 1 clk after mem_en with mem_we=0
//  rgb         out  12  registered pixel colour {R,G,B}
// BEHAVIOUR
//  Reset: host_ack=0, host_rdata=0, rgb=0, FSM=IDLE, display pipeline valid bits cleared.
//  Display slot: cycle T with pix_tick&bright -> mem_en=1, mem_we=0, mem_addr =
//   (vCount>>SCALE_SHIFT)*FB_W + (hCount>>SCALE_SHIFT). T+1: mem_rdata registered;
//   rgb updates at end of T+1 (visible from T+2). pix_tick&!bright -> no RAM access,
//   rgb<=0 with the same 2-cycle latency. Timing gen compensates the latency.
//  Host FSM: IDLE -(host_req)-> ISSUE -(!(pix_tick&bright))-> WAIT -> ACK -> IDLE.
//   ISSUE with display slot pending: stall in ISSUE (at most 1 cycle given pix_tick spacing).
//   ISSUE access: mem_en=1, mem_we=host_we, mem_addr=host_addr, mem_wdata=host_wdata.
//   WAIT: read -> host_rdata<=mem_rdata; write -> host_rdata unchanged.
//   ACK: host_ack=1 exactly one cycle. Min req->ack latency 3 clk, max 4 clk.
//   IDLE re-samples host_req on the cycle after ACK; still high = new transaction.
//  Out of range: host_addr >= FB_W*FB_H -> no RAM access, no stall; read returns 0,
//   ack timing unchanged.
//  Simultaneous: display and host never drive the RAM in the same cycle; display wins.
//  hCount/vCount outside 640x480 with bright=1: address is not clamped; timing gen
//   guarantees bright=0 there.
//  Reset mid-transaction: outstanding host op dropped, no ack; RAM write issued before reset
//   is kept.
// CONFIGURATION
//  VGA_FB_BORDER_EN defined: pixel with bright=1 and hCount in {0,639} or vCount in {0,479}
//   -> rgb=BORDER_RGB (same latency); no RAM read for that pixel, so the slot goes to the host.
//  Not defined: all active pixels come from RAM; BORDER_RGB unused.
// TESTING
//  Reset low mid-frame -> rgb=0, host_ack=0 next cycle; FSM IDLE after release.
//  Host write addr 0x0051 data 12'hF00, no pix_tick -> mem_we pulse 1 clk, ack 3 clk
//   after req; pix_tick at hCount=8, vCount=8 -> rgb=12'hF00 2 clk later.
//  Host read requested on same cycle as ISSUE meets pix_tick&bright -> host access delayed
//   1 clk, ack at 4 clk, host_rdata correct; display read unaffected.
//  pix_tick with bright=0 -> mem_en=0, rgb=0 after 2 clk; queued host op proceeds in that slot.
//  Host read addr 4800 -> mem_en stays 0, ack at 3 clk, host_rdata=0.
//  With VGA_FB_BORDER_EN: pix_tick at hCount=0, vCount=100 -> rgb=12'hFFF, mem_en=0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares the single-port framebuffer RAM between VGA scan-out and one host port.
// Latency: rgb is valid 2 clk after pix_tick; host req->ack takes 3 clk, or 4 clk if it collides with a display read.
// Backpressure: scan-out always wins the RAM; the host is stalled in ISSUE for at most one cycle, and req is held until ack.
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   pix_tick, hCount, vCount, bright  pixel strobe and scan position from the timing generator
//   host_req/we/addr/wdata            host request (held until host_ack)
//   host_ack, host_rdata              one-cycle completion pulse and read data
//   mem_en/we/addr/wdata, mem_rdata   framebuffer RAM port (1-clk read latency)
//   rgb                               registered {R,G,B} to the VGA pins
// Optional build macro: VGA_FB_BORDER_EN draws a 1-pixel BORDER_RGB frame without touching RAM.
module vga_fb_arbiter #(
  parameter int          FB_W        = 80,
  parameter int          FB_H        = 60,
  parameter int          SCALE_SHIFT = 3,
  parameter int          AW          = 13,
  parameter logic [11:0] BORDER_RGB  = 12'hFFF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_tick,
  input  logic [9:0]    hCount,
  input  logic [9:0]    vCount,
  input  logic          bright,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [11:0]   host_wdata,
  output logic          host_ack,
  output logic [11:0]   host_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [11:0]   mem_wdata,
  input  logic [11:0]   mem_rdata,
  output logic [11:0]   rgb
);

  localparam int CELLS = FB_W * FB_H;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} hostState_t;

  hostState_t    hostState;
  logic          isBorder;
  logic          dispSlot;
  logic          hostInRange;
  logic          hostIssue;
  logic [AW-1:0] dispAddr;

  // Host op captured at issue time, used in WAIT to pick the read result.
  logic          opRead;
  logic          opValid;

  // One-stage pixel pipeline: what to show once the RAM data (if any) returns.
  logic          pixVld;
  logic          pixFromRam;
  logic [11:0]   pixColor;

`ifdef VGA_FB_BORDER_EN
  assign isBorder = (hCount == 10'd0) || (hCount == 10'd639) ||
                    (vCount == 10'd0) || (vCount == 10'd479);
`else
  assign isBorder = 1'b0;
`endif

  // Border pixels are constant colour, so they do not occupy the RAM slot.
  assign dispSlot    = pix_tick & bright & ~isBorder;
  assign dispAddr    = AW'(vCount >> SCALE_SHIFT) * AW'(FB_W) + AW'(hCount >> SCALE_SHIFT);
  assign hostInRange = (32'(host_addr) < 32'(CELLS));
  assign hostIssue   = (hostState == S_ISSUE) && !dispSlot && hostInRange;

  // RAM port mux: display first, host only when the display does not need it.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 12'h000;
    if (dispSlot) begin
      mem_en   = 1'b1;
      mem_addr = dispAddr;
    end else if (hostIssue) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end
  end

  // Display pipeline: T = slot, T+1 = RAM data present, rgb registered at end of T+1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixVld     <= 1'b0;
      pixFromRam <= 1'b0;
      pixColor   <= 12'h000;
      rgb        <= 12'h000;
    end else begin
      pixVld     <= pix_tick;
      pixFromRam <= dispSlot;
      pixColor   <= (bright && isBorder) ? BORDER_RGB : 12'h000;
      if (pixVld) begin
        rgb <= pixFromRam ? mem_rdata : pixColor;
      end
    end
  end

  // Host FSM with registered ack/rdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hostState  <= S_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= 12'h000;
      opRead     <= 1'b0;
      opValid    <= 1'b0;
    end else begin
      case (hostState)
        S_IDLE: begin
          host_ack <= 1'b0;
          if (host_req) begin
            hostState <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Out-of-range ops never touch RAM, so they need not wait for the slot.
          if (!dispSlot || !hostInRange) begin
            hostState <= S_WAIT;
            opRead    <= ~host_we;
            opValid   <= hostInRange;
          end
        end
        S_WAIT: begin
          if (opRead) begin
            host_rdata <= opValid ? mem_rdata : 12'h000;
          end
          host_ack  <= 1'b1;
          hostState <= S_ACK;
        end
        S_ACK: begin
          host_ack  <= 1'b0;
          hostState <= S_IDLE;
        end
        default: begin
          host_ack  <= 1'b0;
          hostState <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  logic        clk;
  logic        reset_n;
  logic        pix_tick;
  logic [9:0]  hCount;
  logic [9:0]  vCount;
  logic        bright;
  logic        host_req;
  logic        host_we;
  logic [12:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_ack;
  logic [11:0] host_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb;

  int vecCount  = 0;
  int missCount = 0;

  logic [11:0] ram [0:8191];

  vga_fb_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_tick   (pix_tick),
    .hCount     (hCount),
    .vCount     (vCount),
    .bright     (bright),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .rgb        (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port RAM, 1-clk read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs set afterwards apply to that cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel(input logic [9:0] h, input logic [9:0] v, input logic b);
    pix_tick = 1'b1;
    hCount   = h;
    vCount   = v;
    bright   = b;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 12'h000;
    ram[100] = 12'hABC;
    ram[162] = 12'h123;
    ram[960] = 12'h456;
    mem_rdata  = 12'h000;
    pix_tick   = 1'b0;
    hCount     = 10'd0;
    vCount     = 10'd0;
    bright     = 1'b0;
    host_req   = 1'b0;
    host_we    = 1'b0;
    host_addr  = 13'd0;
    host_wdata = 12'h000;
    reset_n    = 1'b1;
    #1 reset_n = 1'b0;
    step(); step();
    checkVal("rst_rgb", 32'(rgb), 32'h0);
    checkVal("rst_ack", 32'(host_ack), 32'h0);
    checkVal("rst_rdata", 32'(host_rdata), 32'h0);
    reset_n = 1'b1;
    step();

    // Host write 0x51 <= F00, no display traffic: ack 3 clk after req.
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'h051; host_wdata = 12'hF00;
    #1 checkVal("wr_idle_en", 32'(mem_en), 32'h0);
    step();
    checkVal("wr_issue_en", 32'(mem_en), 32'h1);
    checkVal("wr_issue_we", 32'(mem_we), 32'h1);
    checkVal("wr_issue_addr", 32'(mem_addr), 32'h51);
    checkVal("wr_issue_wdata", 32'(mem_wdata), 32'hF00);
    step();
    checkVal("wr_wait_we", 32'(mem_we), 32'h0);
    checkVal("wr_wait_ack", 32'(host_ack), 32'h0);
    step();
    checkVal("wr_ack", 32'(host_ack), 32'h1);
    host_req = 1'b0;
    step();
    checkVal("wr_ack_pulse", 32'(host_ack), 32'h0);

    // Display pixel (8,8) maps to cell 81 and shows the colour just written.
    pixel(10'd8, 10'd8, 1'b1);
    #1 checkVal("disp_en", 32'(mem_en), 32'h1);
    checkVal("disp_we", 32'(mem_we), 32'h0);
    checkVal("disp_addr", 32'(mem_addr), 32'h51);
    step();
    pix_tick = 1'b0;
    checkVal("disp_rgb_t1", 32'(rgb), 32'h0);
    step();
    checkVal("disp_rgb_t2", 32'(rgb), 32'hF00);

    // Host read of 100 collides with display pixel (16,16) -> cell 162.
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd100;
    step();
    pixel(10'd16, 10'd16, 1'b1);
    #1 checkVal("col_disp_addr", 32'(mem_addr), 32'd162);
    checkVal("col_disp_we", 32'(mem_we), 32'h0);
    step();
    pix_tick = 1'b0;
    #1 checkVal("col_host_en", 32'(mem_en), 32'h1);
    checkVal("col_host_addr", 32'(mem_addr), 32'd100);
    step();
    checkVal("col_rgb", 32'(rgb), 32'h123);
    checkVal("col_no_ack3", 32'(host_ack), 32'h0);
    step();
    checkVal("col_ack4", 32'(host_ack), 32'h1);
    checkVal("col_rdata", 32'(host_rdata), 32'hABC);
    host_req = 1'b0;
    step();

    // Blank pixel: slot goes to the queued host write, rgb goes to 0.
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'd200; host_wdata = 12'h0F0;
    step();
    pixel(10'd700, 10'd500, 1'b0);
    #1 checkVal("blank_host_en", 32'(mem_en), 32'h1);
    checkVal("blank_host_we", 32'(mem_we), 32'h1);
    checkVal("blank_host_addr", 32'(mem_addr), 32'd200);
    step();
    pix_tick = 1'b0;
    step();
    checkVal("blank_rgb", 32'(rgb), 32'h0);
    checkVal("blank_ack3", 32'(host_ack), 32'h1);
    host_req = 1'b0;
    step();

    // Out-of-range read: no RAM access, ack at 3 clk, data 0.
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd4800;
    step();
    #1 checkVal("oor_en_issue", 32'(mem_en), 32'h0);
    step();
    checkVal("oor_en_wait", 32'(mem_en), 32'h0);
    step();
    checkVal("oor_ack3", 32'(host_ack), 32'h1);
    checkVal("oor_rdata", 32'(host_rdata), 32'h0);
    host_req = 1'b0;
    step();

    // Left-edge pixel (0,100): border colour, or cell 960 from RAM.
    pixel(10'd0, 10'd100, 1'b1);
`ifdef VGA_FB_BORDER_EN
    #1 checkVal("edge_en", 32'(mem_en), 32'h0);
    step();
    pix_tick = 1'b0;
    step();
    checkVal("edge_rgb", 32'(rgb), 32'hFFF);
`else
    #1 checkVal("edge_en", 32'(mem_en), 32'h1);
    checkVal("edge_addr", 32'(mem_addr), 32'd960);
    step();
    pix_tick = 1'b0;
    step();
    checkVal("edge_rgb", 32'(rgb), 32'h456);
`endif

    // Reset in the middle of a host read: op dropped, outputs cleared at once.
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd200;
    step();
    #1 reset_n = 1'b0;
    #1 checkVal("mid_rst_rgb", 32'(rgb), 32'h0);
    checkVal("mid_rst_ack", 32'(host_ack), 32'h0);
    step();
    reset_n  = 1'b1;
    host_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checkVal("mid_rst_no_ack", 32'(host_ack), 32'h0);
    end

    // FSM is idle again; the write done before reset survived.
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'd200;
    step(); step(); step();
    checkVal("post_rst_ack3", 32'(host_ack), 32'h1);
    checkVal("post_rst_rdata", 32'(host_rdata), 32'h0F0);
    host_req = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
